// File: rtl/iob_wbm2iob_pkg.sv
// Shared types and constants for the Wishbone-to-IOb bridge.
// The optional bus timeout is selected with the IOB_WBM2IOB_TIMEOUT_EN macro.
package iob_wbm2iob_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int TMO_CNT_W  = 16;

   function automatic int wstrb_w(input int data_w);
      return data_w / 8;
   endfunction

   localparam int WSTRB_W = wstrb_w(DEF_DATA_W);

endpackage

// File: rtl/iob_wbm2iob_if.sv
// Bundles the MAC Wishbone DMA port and the IOb master port of the bridge.
// slave: the bridge's view; master: the environment (MAC + memory) view.
interface iob_wbm2iob_if
   import iob_wbm2iob_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = DEF_DATA_W
);
   localparam int STRB_W = wstrb_w(DATA_W);

   logic [ADDR_W-1:0] wb_adr_i;
   logic [STRB_W-1:0] wb_sel_i;
   logic              wb_we_i;
   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic [DATA_W-1:0] wb_dat_i;
   logic [DATA_W-1:0] wb_dat_o;
   logic              wb_ack_o;
   logic              wb_err_o;

   logic              m_valid;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [STRB_W-1:0] m_wstrb;
   logic [DATA_W-1:0] m_rdata;
   logic              m_ready;

   modport slave (
      input  wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o,
      output m_valid, m_addr, m_wdata, m_wstrb,
      input  m_rdata, m_ready
   );

   modport master (
      output wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o,
      input  m_valid, m_addr, m_wdata, m_wstrb,
      output m_rdata, m_ready
   );

endinterface

// File: rtl/iob_wbm2iob_timer.sv
// Up-counter that flags when LIMIT counted cycles have elapsed; holds once expired.
// Only instantiated when IOB_WBM2IOB_TIMEOUT_EN is defined.
module iob_wbm2iob_timer
   import iob_wbm2iob_pkg::*;
#(
   parameter int unsigned LIMIT = 255,
   parameter int          CNT_W = TMO_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expiry is flagged on the last counted cycle so the owner can act on that same edge.
   assign expired_o = (cnt_q == CNT_W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/iob_wbm2iob_bridge.sv
// Registered Wishbone-classic DMA master to IOb master bridge (IDLE/REQ/RESP).
// Define IOB_WBM2IOB_TIMEOUT_EN to return wb_err_o after TIMEOUT cycles without m_ready.
module iob_wbm2iob_bridge
   import iob_wbm2iob_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   iob_wbm2iob_if.slave bus
);

   localparam int STRB_W = wstrb_w(DATA_W);

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("iob_wbm2iob_bridge: TIMEOUT must be within 1..65535");
   end

   state_t            state_q;
   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic              we_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ack_q;
   logic              err_q;
   logic              start;
   logic              tmo_expired;

   assign start = bus.wb_cyc_i & bus.wb_stb_i;

`ifdef IOB_WBM2IOB_TIMEOUT_EN
   iob_wbm2iob_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   ((state_q == IDLE) && start),
      .en_i      ((state_q == REQ) && !bus.m_ready),
      .expired_o (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  addr_q  <= bus.wb_adr_i;
                  wdata_q <= bus.wb_dat_i;
                  wstrb_q <= bus.wb_we_i ? bus.wb_sel_i : '0;
                  we_q    <= bus.wb_we_i;
                  valid_q <= 1'b1;
                  state_q <= REQ;
               end
            end
            // m_ready takes priority over a timeout expiring on the same edge.
            REQ: begin
               if (bus.m_ready) begin
                  valid_q <= 1'b0;
                  if (!we_q) begin
                     rdata_q <= bus.m_rdata;
                  end
                  ack_q   <= 1'b1;
                  state_q <= RESP;
               end else if (tmo_expired) begin
                  valid_q <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end
            end
            RESP: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.m_valid  = valid_q;
   assign bus.m_addr   = addr_q;
   assign bus.m_wdata  = wdata_q;
   assign bus.m_wstrb  = wstrb_q;
   assign bus.wb_dat_o = rdata_q;
   assign bus.wb_ack_o = ack_q;
   assign bus.wb_err_o = err_q;

endmodule
